in_arb_stats_regs: RTL and testbench

IN_ARB_STATS_REGS -- requirements
Module: in_arb_stats_regs

---
 rtl/in_arb_stats_regs.sv | 141 ++++++++++++++
 tb/tb_in_arb_stats_regs.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/in_arb_stats_regs.sv
// in_arb_stats_regs: input-arbiter packet counters, state snoop and leading-word capture on the register ring
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef IN_ARB_REG_ADDR_WIDTH
`define IN_ARB_REG_ADDR_WIDTH 6
`endif
`ifndef IN_ARB_BLOCK_ADDR
`define IN_ARB_BLOCK_ADDR 17'h00001
`endif
module in_arb_stats_regs #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_QUEUES = 8,
  parameter int CAPTURE_WORDS = 2,
  parameter logic [`UDP_REG_ADDR_WIDTH-`IN_ARB_REG_ADDR_WIDTH-1:0] BLOCK_TAG = `IN_ARB_BLOCK_ADDR,
  localparam int AW = `UDP_REG_ADDR_WIDTH,
  localparam int DW = `CPCI_NF2_DATA_WIDTH,
  localparam int QW = NUM_QUEUES > 1 ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [AW-1:0]                reg_addr_in,
  input  logic [DW-1:0]                reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [AW-1:0]                reg_addr_out,
  output logic [DW-1:0]                reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic                         state,
  input  logic                         out_rdy,
  input  logic                         out_wr,
  input  logic [CTRL_WIDTH-1:0]        out_ctrl,
  input  logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         eop,
  input  logic [QW-1:0]                eop_queue
);
  localparam int RW = `IN_ARB_REG_ADDR_WIDTH;
  localparam int WPW = DATA_WIDTH/32;
  localparam int CAP_BASE = 3 + NUM_QUEUES;
  localparam int NUM_REGS = CAP_BASE + CAPTURE_WORDS*(WPW+1);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int WW = $clog2(CAPTURE_WORDS+1);
  logic [31:0] total;
  logic [31:0] qpkts [NUM_QUEUES];
  logic [1:0] control;
  logic state_q, out_rdy_q, in_pkt;
  logic [WW-1:0] word_idx;
  logic [DATA_WIDTH-1:0] cap_data [CAPTURE_WORDS];
  logic [CTRL_WIDTH-1:0] cap_ctrl [CAPTURE_WORDS];
  logic [31:0] regs [NUM_REGS];
  logic tag_hit, bad, hit, rd_clr, ctl_wr, first_word, cap_en;
  logic [IDX_W-1:0] idx;
  logic [WW-1:0] cap_idx;
  function automatic logic [31:0] cnt_next(input logic [31:0] c, input logic inc, input logic clr);
    return clr ? 32'(inc) : (inc && c != '1) ? c + 32'd1 : c;
  endfunction
  // any index at or past NUM_REGS also covers nonzero bits between index and tag
  always_comb begin
    tag_hit = reg_addr_in[AW-1:RW] == BLOCK_TAG;
    bad = 32'(reg_addr_in[RW-1:0]) >= NUM_REGS;
    idx = reg_addr_in[IDX_W-1:0];
    hit = reg_req_in && tag_hit;
    rd_clr = hit && reg_rd_wr_L_in && !bad && !control[1];
    ctl_wr = hit && !reg_rd_wr_L_in && !bad && idx == IDX_W'(2);
    first_word = !in_pkt && out_ctrl == '0;
    cap_idx = first_word ? '0 : word_idx;
    cap_en = out_wr && !control[0] && 32'(cap_idx) < CAPTURE_WORDS;
  end
  always_comb begin
    regs[0] = total;
    regs[1] = {30'b0, out_rdy_q, state_q};
    regs[2] = {30'b0, control};
    for (int q = 0; q < NUM_QUEUES; q++) regs[3+q] = qpkts[q];
    for (int k = 0; k < CAPTURE_WORDS; k++) begin
      for (int w = 0; w < WPW; w++) regs[CAP_BASE+k*(WPW+1)+w] = cap_data[k][w*32 +: 32];
      regs[CAP_BASE+k*(WPW+1)+WPW] = 32'(cap_ctrl[k]);
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      reg_req_out <= 1'b0;
      reg_ack_out <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out <= '0;
      reg_data_out <= '0;
      reg_src_out <= '0;
    end else begin
      reg_req_out <= reg_req_in;
      reg_ack_out <= hit || reg_ack_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out <= reg_addr_in;
      reg_src_out <= reg_src_in;
      reg_data_out <= !hit ? reg_data_in : bad ? DW'(32'hDEADBEEF) : reg_rd_wr_L_in ? DW'(regs[idx]) : reg_data_in;
    end
  // a clearing read that coincides with an event leaves the counter at 1
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      total <= '0;
      qpkts <= '{default: '0};
      control <= '0;
      state_q <= 1'b0;
      out_rdy_q <= 1'b0;
    end else begin
      total <= cnt_next(total, eop, rd_clr && idx == '0);
      for (int q = 0; q < NUM_QUEUES; q++)
        qpkts[q] <= cnt_next(qpkts[q], eop && eop_queue == QW'(q), rd_clr && idx == IDX_W'(3+q));
      if (ctl_wr) control <= reg_data_in[1:0];
      state_q <= state;
      out_rdy_q <= out_rdy;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in_pkt <= 1'b0;
      word_idx <= '0;
      cap_data <= '{default: '0};
      cap_ctrl <= '{default: '0};
    end else if (out_wr) begin
      if (first_word) begin
        in_pkt <= 1'b1;
        word_idx <= WW'(1);
      end else if (in_pkt) begin
        if (out_ctrl != '0) in_pkt <= 1'b0;
        if (32'(word_idx) < CAPTURE_WORDS) word_idx <= word_idx + 1'b1;
      end
      for (int k = 0; k < CAPTURE_WORDS; k++)
        if (cap_en && cap_idx == WW'(k)) begin
          cap_data[k] <= out_data;
          cap_ctrl[k] <= out_ctrl;
        end
    end
endmodule

// File: tb/tb_in_arb_stats_regs.sv
// tb_in_arb_stats_regs: directed and randomized checks of the stats block against a behavioural model
module tb_in_arb_stats_regs;
  localparam int NQ = 8, CAP = 2, WPW = 2, NREGS = 3 + NQ + CAP*(WPW+1);
  localparam logic [16:0] TAG = 17'h00001;
  logic clk = 1'b0, reset_n = 1'b0;
  logic reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0] reg_src_in;
  logic reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0] reg_src_out;
  logic state, out_rdy, out_wr, eop;
  logic [7:0] out_ctrl;
  logic [63:0] out_data;
  logic [2:0] eop_queue;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_total;
  logic [31:0] m_q [NQ];
  logic [1:0] m_ctl;
  logic m_st, m_rdy, m_in_pkt;
  int m_widx;
  logic [63:0] m_cd [CAP];
  logic [7:0] m_cc [CAP];
  in_arb_stats_regs #(.DATA_WIDTH(64), .NUM_QUEUES(NQ), .CAPTURE_WORDS(CAP), .BLOCK_TAG(TAG)) dut (
    .clk(clk), .reset_n(reset_n),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .state(state), .out_rdy(out_rdy), .out_wr(out_wr), .out_ctrl(out_ctrl), .out_data(out_data),
    .eop(eop), .eop_queue(eop_queue));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return c == 32'hFFFFFFFF ? c : c + 32'd1;
  endfunction
  function automatic logic [31:0] model_reg(input int ix);
    int j, k, w;
    if (ix == 0) return m_total;
    if (ix == 1) return {30'b0, m_rdy, m_st};
    if (ix == 2) return {30'b0, m_ctl};
    if (ix < 3 + NQ) return m_q[ix-3];
    j = ix - 3 - NQ;
    k = j / (WPW+1);
    w = j % (WPW+1);
    return w < WPW ? m_cd[k][w*32 +: 32] : {24'b0, m_cc[k]};
  endfunction
  task automatic model_reset();
    m_total = 0; m_ctl = 0; m_st = 0; m_rdy = 0; m_in_pkt = 0; m_widx = 0;
    for (int q = 0; q < NQ; q++) m_q[q] = 0;
    for (int k = 0; k < CAP; k++) begin m_cd[k] = 0; m_cc[k] = 0; end
  endtask
  task automatic idle();
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 1; reg_addr_in = 0; reg_data_in = 0; reg_src_in = 0;
    state = 0; out_rdy = 0; out_wr = 0; out_ctrl = 0; out_data = 0; eop = 0; eop_queue = 0;
  endtask
  task automatic tick();
    bit hit, rd, bad, clr, fw, eq;
    int ix, cidx;
    logic [31:0] exp_d, x_data;
    logic x_ack, x_req, x_rw;
    logic [22:0] x_addr;
    logic [1:0] x_src;
    hit = reg_req_in && reg_addr_in[22:6] == TAG;
    ix = int'(reg_addr_in[5:0]);
    rd = reg_rd_wr_L_in;
    bad = ix >= NREGS;
    exp_d = !hit ? reg_data_in : bad ? 32'hDEADBEEF : rd ? model_reg(ix) : reg_data_in;
    x_ack = hit || reg_ack_in; x_req = reg_req_in; x_rw = reg_rd_wr_L_in; x_addr = reg_addr_in; x_src = reg_src_in;
    x_data = exp_d;
    clr = hit && rd && !bad && !m_ctl[1];
    m_total = (clr && ix == 0) ? 32'(eop) : eop ? sat_inc(m_total) : m_total;
    for (int q = 0; q < NQ; q++) begin
      eq = eop && int'(eop_queue) == q;
      m_q[q] = (clr && ix == 3 + q) ? 32'(eq) : eq ? sat_inc(m_q[q]) : m_q[q];
    end
    fw = !m_in_pkt && out_ctrl == 0;
    if (out_wr) begin
      cidx = fw ? 0 : m_widx;
      if (!m_ctl[0] && cidx < CAP) begin m_cd[cidx] = out_data; m_cc[cidx] = out_ctrl; end
      if (fw) begin m_in_pkt = 1; m_widx = 1; end
      else if (m_in_pkt) begin
        if (out_ctrl != 0) m_in_pkt = 0;
        if (m_widx < CAP) m_widx++;
      end
    end
    if (hit && !rd && !bad && ix == 2) m_ctl = reg_data_in[1:0];
    m_st = state; m_rdy = out_rdy;
    @(posedge clk); #1;
    chk("ack", 32'(reg_ack_out), 32'(x_ack));
    chk("data", reg_data_out, x_data);
    chk("req_out", 32'(reg_req_out), 32'(x_req));
    chk("rw_out", 32'(reg_rd_wr_L_out), 32'(x_rw));
    chk("addr_out", 32'(reg_addr_out), 32'(x_addr));
    chk("src_out", 32'(reg_src_out), 32'(x_src));
  endtask
  task automatic rd(input int ix);
    reg_req_in = 1; reg_rd_wr_L_in = 1; reg_addr_in = {TAG, 6'(ix)};
    tick();
    reg_req_in = 0;
  endtask
  task automatic wr(input int ix, input logic [31:0] d);
    reg_req_in = 1; reg_rd_wr_L_in = 0; reg_addr_in = {TAG, 6'(ix)}; reg_data_in = d;
    tick();
    reg_req_in = 0; reg_rd_wr_L_in = 1; reg_data_in = 0;
  endtask
  task automatic ev(input int q);
    eop = 1; eop_queue = 3'(q);
    tick();
    eop = 0;
  endtask
  task automatic word(input logic [7:0] c, input logic [63:0] d);
    out_wr = 1; out_ctrl = c; out_data = d;
    tick();
    out_wr = 0; out_ctrl = 0;
  endtask
  initial begin
    logic [63:0] a, b, p;
    int r;
    idle();
    model_reset();
    #1;
    chk("rst_ack", 32'(reg_ack_out), 0);
    chk("rst_data", reg_data_out, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) ev(2);
    rd(5); chk("q2_three", reg_data_out, 3);
    rd(5); chk("q2_cleared", reg_data_out, 0);
    reg_req_in = 1; reg_addr_in = {17'h00005, 6'd3}; reg_data_in = 32'h12345678; reg_ack_in = 1; reg_src_in = 2;
    tick(); chk("pass_data", reg_data_out, 32'h12345678);
    idle();
    a = 64'hA0A0_A1A1_A2A2_A3A3; b = 64'hB0B0_B1B1_B2B2_B3B3;
    word(8'hFF, 64'h1111_2222_3333_4444);
    word(8'h00, a); word(8'h00, b); word(8'h01, 64'hC0C0_C1C1_C2C2_C3C3);
    rd(11); chk("slot0_lsw", reg_data_out, a[31:0]);
    rd(15); chk("slot1_msw", reg_data_out, b[63:32]);
    rd(13); chk("slot0_ctrl", reg_data_out, 0);
    rd(NREGS); chk("bad_idx", reg_data_out, 32'hDEADBEEF);
    wr(2, 1); chk("ctl_echo", reg_data_out, 1);
    word(8'h00, 64'hD); word(8'h01, 64'hE);
    rd(12); chk("frozen_slot0", reg_data_out, a[63:32]);
    rd(14); chk("frozen_slot1", reg_data_out, b[31:0]);
    wr(2, 0);
    word(8'h00, 64'hF0F0_0000_F1F1_0000); word(8'h02, 64'h6);
    rd(11); chk("unfrozen_slot0", reg_data_out, 32'hF1F1_0000);
    rd(0);
    wr(2, 2);
    ev(0); ev(7);
    rd(0); chk("sticky_rd1", reg_data_out, 2);
    rd(0); chk("sticky_rd2", reg_data_out, 2);
    wr(0, 32'h0); chk("wr_total_ack", 32'(reg_ack_out), 1);
    rd(0); chk("sticky_after_wr", reg_data_out, 2);
    force dut.total = 32'hFFFFFFFD;
    #1 release dut.total;
    m_total = 32'hFFFFFFFD;
    repeat (3) ev(1);
    rd(0); chk("sat_total", reg_data_out, 32'hFFFFFFFF);
    wr(2, 0);
    rd(0); chk("sat_clear_rd", reg_data_out, 32'hFFFFFFFF);
    eop = 1; eop_queue = 3; rd(0); eop = 0;
    chk("coinc_rd", reg_data_out, 0);
    rd(0); chk("coinc_kept", reg_data_out, 1);
    word(8'h00, 64'h99);
    reg_req_in = 1; reg_addr_in = {TAG, 6'd2}; reg_src_in = 3;
    tick();
    #3 reset_n = 0;
    #1;
    chk("arst_ack", 32'(reg_ack_out), 0);
    chk("arst_req", 32'(reg_req_out), 0);
    chk("arst_addr", 32'(reg_addr_out), 0);
    chk("arst_src", 32'(reg_src_out), 0);
    @(posedge clk); #1;
    chk("rst_no_ack", 32'(reg_ack_out), 0);
    idle();
    model_reset();
    reset_n = 1;
    tick();
    rd(0); chk("rst_total", reg_data_out, 0);
    p = 64'h5555_6666_7777_8888;
    word(8'h00, p); word(8'h04, 64'h1);
    rd(11); chk("rst_slot0", reg_data_out, p[31:0]);
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      reg_req_in = $urandom_range(0, 2) == 0;
      reg_rd_wr_L_in = $urandom_range(0, 3) != 0;
      reg_addr_in = r <= 6 ? {TAG, 6'($urandom_range(0, NREGS-1))} :
                    r == 7 ? {TAG, 6'($urandom_range(NREGS, 63))} :
                    {TAG ^ 17'($urandom_range(1, 1000)), 6'($urandom_range(0, 63))};
      reg_data_in = $urandom;
      reg_src_in = 2'($urandom);
      reg_ack_in = $urandom_range(0, 3) == 0;
      state = 1'($urandom); out_rdy = 1'($urandom);
      out_wr = $urandom_range(0, 1) == 0;
      r = $urandom_range(0, 5);
      out_ctrl = r < 3 ? 8'h00 : r == 3 ? 8'hFF : r == 4 ? 8'h01 : 8'h80;
      out_data = {$urandom, $urandom};
      eop = $urandom_range(0, 2) == 0;
      eop_queue = 3'($urandom);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
